// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_bank clock-enable generator.
package clk_div_pkg;

  localparam int unsigned DefCntW = 20;
  localparam logic [DefCntW-1:0] DefDiv = 20'h3D090;

  // Channel state is held at a fixed maximum width; narrower builds leave upper bits at zero.
  localparam int unsigned MaxCntW = 32;

  typedef struct packed {
    logic [MaxCntW-1:0] cnt;
    logic [MaxCntW-1:0] div;
    logic [MaxCntW-1:0] pend_div;
    logic               pend_v;
  } chan_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, live/pending divisor, registered tick and clk_out.
// CLKDIV_SYNC_EN enables the sync realign input; otherwise sync_i is ignored.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned        CNT_W       = DefCntW,
  parameter logic [CNT_W-1:0]   DEFAULT_DIV = CNT_W'(DefDiv)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  logic             sync_i,
  output logic             tick_o,
  output logic             clk_out_o
);

  chan_state_t        st_q, st_d;
  logic               tick_q, tick_d;
  logic               clk_out_q, clk_out_d;
  logic [MaxCntW-1:0] pend_div_eff, new_div;
  logic               pend_v_eff;
  logic               restart;

`ifdef CLKDIV_SYNC_EN
  assign restart = sync_i | ~en_i;
`else
  logic unused_sync;
  assign unused_sync = sync_i;
  assign restart     = ~en_i;
`endif

  always_comb begin
    st_d      = st_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;

    // A write in this cycle counts as pending so a coincident reload picks it up.
    pend_div_eff  = wr_i ? MaxCntW'(wr_div_i) : st_q.pend_div;
    pend_v_eff    = wr_i | st_q.pend_v;
    new_div       = pend_v_eff ? pend_div_eff : st_q.div;
    st_d.pend_div = pend_div_eff;
    st_d.pend_v   = pend_v_eff;

    if (restart) begin
      st_d.cnt    = '0;
      st_d.div    = new_div;
      st_d.pend_v = 1'b0;
      clk_out_d   = 1'b0;
    end else if (st_q.cnt == st_q.div) begin
      st_d.cnt    = '0;
      st_d.div    = new_div;
      st_d.pend_v = 1'b0;
      tick_d      = 1'b1;
      clk_out_d   = ~clk_out_q;
    end else begin
      st_d.cnt    = st_q.cnt + MaxCntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q      <= '{cnt: '0, div: MaxCntW'(DEFAULT_DIV), pend_div: '0, pend_v: 1'b0};
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable generator: decodes divisor writes and fans out to channels.
// CLKDIV_SYNC_EN enables the sync input that realigns all channels.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      CNT_W       = DefCntW,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DefDiv)
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      wr_en,
  input  logic [idx_w(NUM_CH)-1:0]  wr_ch,
  input  logic [CNT_W-1:0]          wr_div,
  input  logic                      sync,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         clk_out
);

  localparam int unsigned IdxW = idx_w(NUM_CH);

  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range indices match no channel and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_en && (wr_ch == IdxW'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i     (CLK),
      .reset_i   (reset),
      .en_i      (ch_en[g]),
      .wr_i      (wr_sel[g]),
      .wr_div_i  (wr_div),
      .sync_i    (sync),
      .tick_o    (tick[g]),
      .clk_out_o (clk_out[g])
    );
  end

endmodule
